decode_hazard_ctrl: RTL and testbench

//  Hazard and write-port controller for the decode stage and register file.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/decode_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared decode-stage definitions: datapath widths, divide-tracking FSM encoding
// and the register source-match helper used by the hazard logic.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] DHC_IDLE = 2'd0;
  localparam logic [1:0] DHC_BUSY = 2'd1;
  localparam logic [1:0] DHC_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DHC_IDLE,
    ST_BUSY = DHC_BUSY,
    ST_HOLD = DHC_HOLD
  } dhc_state_e;

  // True when the decode instruction actually reads register r through either source port.
  function automatic logic src_match(input logic                  use_rs1,
                                     input logic [REG_ADDR_W-1:0] rs1,
                                     input logic                  use_rs2,
                                     input logic [REG_ADDR_W-1:0] rs2,
                                     input logic [REG_ADDR_W-1:0] r);
    return (use_rs1 && (rs1 == r)) || (use_rs2 && (rs2 == r));
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: load-use and divide stalls, divider launch,
// and arbitration of the single register-file write port.
module decode_hazard_ctrl
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_flush,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_wr_rd,
  input  logic                  id_is_div,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic [XLEN-1:0]       wb_wr_data,
  input  logic                  div_done,
  input  logic [XLEN-1:0]       div_result,
  output logic                  stall_id,
  output logic                  div_start,
  output logic                  div_busy,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]       rf_wr_data
);

  dhc_state_e            state, state_nxt, eff_state;
  logic                  pend_v, pend_v_nxt, eff_pend_v;
  logic [REG_ADDR_W-1:0] pend_rd, pend_rd_nxt;
  logic [XLEN-1:0]       buf_data, buf_data_nxt;
  logic                  load_use, div_haz, struct_haz;
  logic                  div_wr, hold_wr;

  // While reset is held the registers may still carry a stale divide, so outputs see a clean IDLE.
  assign eff_state  = rst ? ST_IDLE : state;
  assign eff_pend_v = pend_v & ~rst;

  assign load_use   = ex_valid & ex_mem_read & (ex_rd != '0) &
                      src_match(id_use_rs1, id_rs1, id_use_rs2, id_rs2, ex_rd);
  assign div_haz    = eff_pend_v & (pend_rd != '0) &
                      (src_match(id_use_rs1, id_rs1, id_use_rs2, id_rs2, pend_rd) |
                       (id_wr_rd & (id_rd == pend_rd)));
  assign struct_haz = id_is_div & (eff_state != ST_IDLE);

  assign stall_id  = id_valid & (load_use | div_haz | struct_haz);
  assign div_start = id_valid & ~stall_id & ~id_flush & id_is_div & ~rst;
  assign div_busy  = (eff_state != ST_IDLE);

  always_comb begin
    state_nxt    = state;
    pend_v_nxt   = pend_v;
    pend_rd_nxt  = pend_rd;
    buf_data_nxt = buf_data;
    div_wr       = 1'b0;
    hold_wr      = 1'b0;
    case (eff_state)
      ST_IDLE: begin
        if (div_start) begin
          state_nxt   = ST_BUSY;
          pend_rd_nxt = id_rd;
          pend_v_nxt  = (id_rd != '0);
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          if (!wb_wr_en) begin
            div_wr     = pend_v;
            pend_v_nxt = 1'b0;
            state_nxt  = ST_IDLE;
          end else begin
            buf_data_nxt = div_result;
            state_nxt    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!wb_wr_en) begin
          hold_wr    = pend_v;
          pend_v_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pend_v   <= 1'b0;
      pend_rd  <= '0;
      buf_data <= '0;
    end else begin
      state    <= state_nxt;
      pend_v   <= pend_v_nxt;
      pend_rd  <= pend_rd_nxt;
      buf_data <= buf_data_nxt;
    end
  end

  // Writeback always owns the port; a late divide result only takes an otherwise idle cycle.
  always_comb begin
    rf_wr_en   = wb_wr_en;
    rf_wr_addr = wb_wr_addr;
    rf_wr_data = wb_wr_data;
    if (!wb_wr_en) begin
      if (div_wr) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = pend_rd;
        rf_wr_data = div_result;
      end else if (hold_wr) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = pend_rd;
        rf_wr_data = buf_data;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: directed pipeline scenarios followed by
// random traffic, checked against a queue-based model of the outstanding divide.
module tb_decode_hazard_ctrl;
  import rv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  id_valid, id_flush;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic                  id_use_rs1, id_use_rs2, id_wr_rd, id_is_div;
  logic                  ex_valid, ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb_wr_en;
  logic [REG_ADDR_W-1:0] wb_wr_addr;
  logic [XLEN-1:0]       wb_wr_data;
  logic                  div_done;
  logic [XLEN-1:0]       div_result;
  logic                  stall_id, div_start, div_busy, rf_wr_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [XLEN-1:0]       rf_wr_data;

  always #5 clk = ~clk;

  decode_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wr_rd(id_wr_rd), .id_is_div(id_is_div),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .div_done(div_done), .div_result(div_result),
    .stall_id(stall_id), .div_start(div_start), .div_busy(div_busy),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  typedef struct packed {
    logic        rst;
    logic        id_valid, id_flush;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, wr_rd, is_div;
    logic        ex_valid, ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        div_done;
    logic [31:0] div_res;
  } stim_t;

  typedef struct packed {
    logic        stall, start, busy, wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  // At most one divide is ever in flight; has_result marks a result parked behind writeback.
  typedef struct {
    logic [4:0]  rd;
    bit          has_result;
    logic [31:0] value;
  } div_rec_t;

  exp_t     exp_q[$];
  div_rec_t outstanding[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  function automatic bit reads(input stim_t s, input logic [4:0] r);
    return (s.use1 && s.rs1 == r) || (s.use2 && s.rs2 == r);
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t     e;
    div_rec_t rec;
    bit       have, lu, dv, sh;
    @(posedge clk);
    #1;
    rst        = s.rst;
    id_valid   = s.id_valid;   id_flush   = s.id_flush;
    id_rs1     = s.rs1;        id_rs2     = s.rs2;       id_rd = s.rd;
    id_use_rs1 = s.use1;       id_use_rs2 = s.use2;
    id_wr_rd   = s.wr_rd;      id_is_div  = s.is_div;
    ex_valid   = s.ex_valid;   ex_mem_read = s.ex_mem_read; ex_rd = s.ex_rd;
    wb_wr_en   = s.wb_en;      wb_wr_addr = s.wb_addr;   wb_wr_data = s.wb_data;
    div_done   = s.div_done;   div_result = s.div_res;

    have = (outstanding.size() > 0) && !s.rst;
    lu   = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) && reads(s, s.ex_rd);
    dv   = 1'b0;
    if (have && outstanding[0].rd != 0)
      dv = reads(s, outstanding[0].rd) || (s.wr_rd && s.rd == outstanding[0].rd);
    sh   = s.is_div && have;

    e       = '0;
    e.stall = s.id_valid && (lu || dv || sh);
    e.start = s.id_valid && !e.stall && !s.id_flush && s.is_div && !s.rst;
    e.busy  = have;
    e.wr_en = s.wb_en;
    e.addr  = s.wb_addr;
    e.data  = s.wb_data;

    if (s.rst) begin
      outstanding.delete();
    end else if (have) begin
      rec = outstanding[0];
      if (!rec.has_result && s.div_done && s.wb_en) begin
        outstanding[0].has_result = 1'b1;
        outstanding[0].value      = s.div_res;
      end else if (!s.wb_en && (rec.has_result || s.div_done)) begin
        if (rec.rd != 0) begin
          e.wr_en = 1'b1;
          e.addr  = rec.rd;
          e.data  = rec.has_result ? rec.value : s.div_res;
        end
        void'(outstanding.pop_front());
      end
    end
    if (e.start) begin
      rec.rd = s.rd; rec.has_result = 1'b0; rec.value = '0;
      outstanding.push_back(rec);
    end
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("stall_id",  {31'd0, stall_id},  {31'd0, e.stall});
    cmp("div_start", {31'd0, div_start}, {31'd0, e.start});
    cmp("div_busy",  {31'd0, div_busy},  {31'd0, e.busy});
    cmp("rf_wr_en",  {31'd0, rf_wr_en},  {31'd0, e.wr_en});
    if (e.wr_en) begin
      cmp("rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, e.addr});
      cmp("rf_wr_data", rf_wr_data, e.data);
    end
  endtask

  // Monitor: the DUT presents a response every cycle, compared mid-cycle away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t id_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic is_div);
    stim_t s;
    s = idle_stim();
    s.id_valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.use1 = 1'b1; s.use2 = 1'b1; s.wr_rd = 1'b1; s.is_div = is_div;
    return s;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] pool [5];
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7};
    return pool[$urandom_range(0, 4)];
  endfunction

  initial begin
    stim_t s;
    int    drain;
    rst = 1'b1; id_valid = 0; id_flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_wr_rd = 0; id_is_div = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0; div_done = 0; div_result = 0;

    s = idle_stim(); s.rst = 1'b1;
    applyStimulus(s);
    s.wb_en = 1'b1; s.wb_addr = 5'd4; s.wb_data = 32'h1111;
    applyStimulus(s);

    s = id_instr(5'd5, 5'd1, 5'd6, 1'b0);
    s.ex_valid = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd5;
    applyStimulus(s);
    s.ex_valid = 1'b0; s.ex_mem_read = 1'b0;
    applyStimulus(s);

    s = id_instr(5'd0, 5'd1, 5'd6, 1'b0);
    s.ex_valid = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd0;
    applyStimulus(s);

    applyStimulus(id_instr(5'd1, 5'd2, 5'd7, 1'b1));
    s = id_instr(5'd7, 5'd2, 5'd8, 1'b0);
    applyStimulus(s);
    applyStimulus(s);
    s.div_done = 1'b1; s.div_res = 32'h0000_1234;
    applyStimulus(s);
    s.div_done = 1'b0;
    applyStimulus(s);

    applyStimulus(id_instr(5'd1, 5'd2, 5'd7, 1'b1));
    s = idle_stim();
    applyStimulus(s);
    s.div_done = 1'b1; s.div_res = 32'h0000_ABCD;
    s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h55;
    applyStimulus(s);
    applyStimulus(idle_stim());
    applyStimulus(idle_stim());

    applyStimulus(id_instr(5'd1, 5'd2, 5'd7, 1'b1));
    s = id_instr(5'd1, 5'd2, 5'd9, 1'b1);
    applyStimulus(s);
    applyStimulus(s);
    s.div_done = 1'b1; s.div_res = 32'h0000_0077;
    applyStimulus(s);
    s.div_done = 1'b0;
    applyStimulus(s);

    s = idle_stim();
    applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0; s.div_done = 1'b1; s.div_res = 32'hDEAD_BEEF;
    applyStimulus(s);
    applyStimulus(id_instr(5'd7, 5'd9, 5'd10, 1'b0));

    for (int i = 0; i < 600; i++) begin
      s = idle_stim();
      s.rst         = ($urandom_range(0, 99) == 0);
      s.id_valid    = ($urandom_range(0, 3) != 0);
      s.id_flush    = ($urandom_range(0, 7) == 0);
      s.rs1         = pick_reg();
      s.rs2         = pick_reg();
      s.rd          = pick_reg();
      s.use1        = $urandom_range(0, 1);
      s.use2        = $urandom_range(0, 1);
      s.wr_rd       = $urandom_range(0, 1);
      s.is_div      = ($urandom_range(0, 3) == 0);
      s.ex_valid    = $urandom_range(0, 1);
      s.ex_mem_read = $urandom_range(0, 1);
      s.ex_rd       = pick_reg();
      s.wb_en       = ($urandom_range(0, 2) == 0);
      s.wb_addr     = 5'($urandom_range(0, 31));
      s.wb_data     = $urandom;
      s.div_done    = ($urandom_range(0, 3) == 0);
      s.div_res     = $urandom;
      applyStimulus(s);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
